mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 24, byte-address width on all address ports.
REQ-002 Parameter TMO, default 16, memory-ack timeout in cycles (2..255).
REQ-003 clk  in  1  single system clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-low (rst=0 resets on next posedge).
REQ-005 cpu_req  in  1  CPU access pending (Ldr|Str decode, SHALL NOT depend combinationally on cpu_stall).
REQ-006 cpu_we  in  1  1=store, 0=load.
REQ-007 cpu_ben  in  1  byte access enable.
REQ-008 cpu_adr  in  AW  CPU byte address.
REQ-009 cpu_wdata  in  32  store data (already byte-lane placed).
REQ-010 cpu_rdata  out  32  load data, valid in the cpu_ack cycle.
REQ-011 cpu_ack  out  1  one-cycle pulse: CPU access complete.
REQ-012 cpu_stall  out  1  = cpu_req & ~cpu_ack; drives the CPU stallX input.
REQ-013 vid_req  in  1  video refresh word-read request.
REQ-014 vid_adr  in  AW  video word address (bits 1:0 ignored).
REQ-015 vid_rdata  out  32  video data, valid in the vid_ack cycle.
REQ-016 vid_ack  out  1  one-cycle pulse: video read complete.
REQ-017 mem_req, mem_we, mem_ben  out  1 each  memory strobes, held until mem_ack.
REQ-018 mem_adr  out  AW; mem_wdata  out  32; mem_rdata  in  32; mem_ack  in  1  memory completion.
REQ-019 err  out  1  sticky timeout flag.

Function
REQ-020 FSM states IDLE, CPU, VID; the memory port SHALL serve exactly one access at a time.
REQ-021 IDLE: only cpu_req -> CPU; only vid_req -> VID; both -> the side not in register last_gnt; none -> stay IDLE.
REQ-022 On entry to CPU/VID, adr/we/ben/wdata SHALL be registered and held stable on mem_* until exit.
REQ-023 mem_req=1 in CPU and VID, 0 in IDLE; VID drives mem_we=0, mem_ben=0.
REQ-024 In CPU/VID, mem_ack=1 -> capture mem_rdata into the owner's rdata register, pulse owner's ack in the same cycle, set last_gnt=owner, go IDLE.
REQ-025 Minimum access latency: request seen in IDLE at cycle n, mem_req at n+1, ack at the mem_ack cycle (>= n+1); IDLE for one cycle between any two accesses.
REQ-026 Timeout counter: clears on entry to CPU/VID, increments each cycle without mem_ack; reaching TMO-1 -> set err, pulse owner's ack with rdata=32'hFFFFFFFF, go IDLE.
REQ-027 mem_ack in IDLE SHALL be ignored.
REQ-028 cpu_rdata/vid_rdata SHALL hold their last value until the next capture.
REQ-029 Requester dropping its req mid-access SHALL NOT abort it; the access completes and ack pulses.
REQ-030 err clears only on reset.

Reset
REQ-031 On rst=0: state=IDLE, last_gnt=CPU (video wins first conflict), counter=0, err=0, cpu_ack=vid_ack=mem_req=0, rdata registers=0.
REQ-032 Reset mid-access SHALL abandon it: mem_req=0 next cycle, no ack pulse.

Structure
REQ-033 State encoding, owner enum and the 32'hFFFFFFFF error word belong in a shared package (mem_pkg).
REQ-034 One sub-module natural: mem_timeout (loadable counter with terminal flag).

Verification
REQ-035 CPU load alone, mem_ack 3 cycles after mem_req -> cpu_stall high 4 cycles, cpu_ack one cycle, cpu_rdata=mem_rdata.
REQ-036 cpu_req and vid_req same cycle after reset -> VID served first, then CPU; repeat -> alternation VID,CPU,VID,CPU.
REQ-037 CPU byte store adr=0x000103, wdata=0x5B000000 -> mem_adr=0x000103, mem_ben=1, mem_we=1, stable until ack.
REQ-038 mem_ack never asserted, TMO=16 -> ack at 16th mem_req cycle, rdata=0xFFFFFFFF, err=1 and stays 1.
REQ-039 rst=0 in the 2nd cycle of a VID access -> no vid_ack, mem_req=0 next cycle, state IDLE.
REQ-040 vid_req dropped after grant -> vid_ack still pulses; spurious mem_ack in IDLE -> no ack pulse.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU/video memory arbiter.
// Holds the FSM encoding, the grant owner and the timeout error word.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_VID  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_t;

    localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;
    localparam int          CNT_W    = 8;

endpackage

// File: rtl/mem_timeout.sv
// Memory-ack watchdog: cleared while the port is idle, counts busy cycles
// without an ack, and flags the last cycle an access is allowed to take.
module mem_timeout #(
    parameter int TMO = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);
    import mem_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TMO - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr)
            cnt <= '0;
        else if (en && !term)
            cnt <= cnt + 1'b1;
    end

    assign term = (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, video refresh) arbiter for a single memory port.
// One access at a time, alternating priority on conflict, ack timeout with sticky err.
module mem_arbiter #(
    parameter int AW  = 24,
    parameter int TMO = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_ben,
    input  logic [AW-1:0] cpu_adr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_adr,
    output logic [31:0]   vid_rdata,
    output logic          vid_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic          mem_ben,
    output logic [AW-1:0] mem_adr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          err
);
    import mem_pkg::*;

    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    state_t        state, state_nx;
    owner_t        last_gnt;
    logic [AW-1:0] adr_q;
    logic          we_q, ben_q;
    logic [31:0]   wdata_q;
    logic [31:0]   cpu_rdata_q, vid_rdata_q, rdata_w;
    logic          busy, done, tmo_hit, grant_cpu, grant_vid;

    mem_timeout #(.TMO(TMO)) u_tmo (
        .clk  (clk),
        .rst  (rst),
        .clr  (!busy),
        .en   (busy && !mem_ack),
        .term (tmo_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // On a conflict the side that did not win last time is granted.
    always_comb begin
        state_nx  = state;
        grant_cpu = 1'b0;
        grant_vid = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req && (!vid_req || last_gnt == OWN_VID)) begin
                    grant_cpu = 1'b1;
                    state_nx  = ST_CPU;
                end else if (vid_req) begin
                    grant_vid = 1'b1;
                    state_nx  = ST_VID;
                end
            end
            ST_CPU, ST_VID: begin
                done = mem_ack || tmo_hit;
                if (done)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_ben   = busy && ben_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;

    // A real ack wins over a coincident timeout; reset suppresses any completion.
    assign rdata_w   = mem_ack ? mem_rdata : ERR_WORD;
    assign cpu_ack   = rst && done && (state == ST_CPU);
    assign vid_ack   = rst && done && (state == ST_VID);
    assign cpu_rdata = cpu_ack ? rdata_w : cpu_rdata_q;
    assign vid_rdata = vid_ack ? rdata_w : vid_rdata_q;
    assign cpu_stall = cpu_req && !cpu_ack;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_gnt    <= OWN_CPU;
            err         <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            adr_q       <= '0;
            we_q        <= 1'b0;
            ben_q       <= 1'b0;
            wdata_q     <= '0;
        end else begin
            if (grant_cpu) begin
                adr_q   <= cpu_adr;
                we_q    <= cpu_we;
                ben_q   <= cpu_ben;
                wdata_q <= cpu_wdata;
            end else if (grant_vid) begin
                adr_q   <= vid_adr & WORD_MASK;
                we_q    <= 1'b0;
                ben_q   <= 1'b0;
                wdata_q <= '0;
            end
            if (done) begin
                last_gnt <= (state == ST_VID) ? OWN_VID : OWN_CPU;
                if (!mem_ack)
                    err <= 1'b1;
            end
            if (cpu_ack)
                cpu_rdata_q <= rdata_w;
            if (vid_ack)
                vid_rdata_q <= rdata_w;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
    localparam int AW  = 24;
    localparam int TMO = 16;

    logic          clk = 1'b0, rst = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, cpu_ben = 1'b0;
    logic [AW-1:0] cpu_adr = '0, vid_adr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic          vid_req = 1'b0;
    logic [31:0]   cpu_rdata, vid_rdata, mem_wdata;
    logic          cpu_ack, cpu_stall, vid_ack, mem_req, mem_we, mem_ben, err;
    logic [AW-1:0] mem_adr;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ack = 1'b0;

    int            n_chk = 0, n_fail = 0;
    int            resp_lat = 0, seen = 0;
    logic [31:0]   resp_data = '0;
    logic          force_ack = 1'b0;

    mem_arbiter #(.AW(AW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ben(cpu_ben), .cpu_adr(cpu_adr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .vid_req(vid_req), .vid_adr(vid_adr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ben(mem_ben), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks after resp_lat completed mem_req cycles (0 = never).
    initial begin
        forever begin
            @(posedge clk);
            #2;
            mem_ack   = force_ack || (resp_lat > 0 && seen == resp_lat);
            mem_rdata = mem_ack ? resp_data : 32'hDEAD_BEEF;
            @(negedge clk);
            if (mem_req && !mem_ack && rst) seen++;
            else seen = 0;
        end
    end

    // Reference model: owner 0=none 1=cpu 2=vid, age = cycles into the access.
    int          m_own = 0, m_age = 0, m_last = 1;
    logic        m_err = 1'b0, m_we = 1'b0, m_ben = 1'b0;
    logic [31:0] m_crd = '0, m_vrd = '0, m_wd = '0;
    logic [AW-1:0] m_adr = '0;
    bit          m_valid = 1'b0;

    always @(negedge clk) begin
        logic        fin, cack, vack;
        logic [31:0] word;
        fin  = (m_own != 0) && (mem_ack || m_age == TMO);
        cack = rst && fin && m_own == 1;
        vack = rst && fin && m_own == 2;
        word = mem_ack ? mem_rdata : 32'hFFFF_FFFF;
        if (m_valid) begin
            check("m_mem_req",   32'(mem_req),   32'(m_own != 0));
            check("m_cpu_ack",   32'(cpu_ack),   32'(cack));
            check("m_vid_ack",   32'(vid_ack),   32'(vack));
            check("m_cpu_stall", 32'(cpu_stall), 32'(cpu_req && !cack));
            check("m_err",       32'(err),       32'(m_err));
            check("m_cpu_rdata", cpu_rdata, cack ? word : m_crd);
            check("m_vid_rdata", vid_rdata, vack ? word : m_vrd);
            if (m_own != 0) begin
                check("m_mem_adr", 32'(mem_adr), 32'(m_adr));
                check("m_mem_we",  32'(mem_we),  32'(m_we));
                check("m_mem_ben", 32'(mem_ben), 32'(m_ben));
                if (m_own == 1) check("m_mem_wdata", mem_wdata, m_wd);
            end
        end
        if (!rst) begin
            m_own = 0; m_age = 0; m_last = 1; m_err = 1'b0; m_crd = '0; m_vrd = '0;
            m_valid = 1'b1;
        end else if (m_own != 0) begin
            if (fin) begin
                if (m_own == 1) m_crd = word;
                else            m_vrd = word;
                if (!mem_ack) m_err = 1'b1;
                m_last = m_own;
                m_own  = 0;
            end else begin
                m_age++;
            end
        end else if (cpu_req || vid_req) begin
            if (cpu_req && vid_req) m_own = (m_last == 1) ? 2 : 1;
            else                    m_own = cpu_req ? 1 : 2;
            m_age = 1;
            if (m_own == 1) begin
                m_adr = cpu_adr; m_we = cpu_we; m_ben = cpu_ben; m_wd = cpu_wdata;
            end else begin
                m_adr = {vid_adr[AW-1:2], 2'b00}; m_we = 1'b0; m_ben = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          stalls, n_mreq, ok;
        logic [31:0] got;
        int          order[$];
        bit          drop_c, drop_v;

        // Reset state
        cyc(); cyc();
        @(negedge clk);
        check("rst_mem_req",   32'(mem_req), 32'd0);
        check("rst_cpu_ack",   32'(cpu_ack), 32'd0);
        check("rst_vid_ack",   32'(vid_ack), 32'd0);
        check("rst_err",       32'(err),     32'd0);
        check("rst_cpu_rdata", cpu_rdata,    32'd0);
        check("rst_vid_rdata", vid_rdata,    32'd0);
        cyc(); rst = 1'b1;

        // CPU load, ack 3 cycles after mem_req
        resp_lat = 3; resp_data = 32'hCAFE_F00D;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_ben = 1'b0; cpu_adr = 24'h000200;
        stalls = 0; ok = 0; got = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cpu_stall) stalls++;
            if (cpu_ack) begin got = cpu_rdata; ok = 1; break; end
            cyc();
        end
        check("t1_ack_seen", 32'(ok), 32'd1);
        check("t1_stall_cycles", 32'(stalls), 32'd4);
        check("t1_rdata", got, 32'hCAFE_F00D);
        cyc(); cpu_req = 1'b0;
        @(negedge clk);
        check("t1_ack_single", 32'(cpu_ack), 32'd0);
        check("t1_rdata_hold", cpu_rdata, 32'hCAFE_F00D);

        // Simultaneous requests after reset: VID,CPU then VID,CPU
        cyc(); rst = 1'b0;
        cyc(); rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            order.delete();
            drop_c = 1'b0; drop_v = 1'b0;
            resp_lat = 1; resp_data = 32'h1111_0000 + 32'(r);
            cpu_req = 1'b1; vid_req = 1'b1; cpu_adr = 24'h000010; vid_adr = 24'h000403;
            for (int i = 0; i < 40 && order.size() < 2; i++) begin
                @(negedge clk);
                if (vid_ack) begin
                    order.push_back(2); drop_v = 1'b1;
                    check("t2_vid_word_adr", 32'(mem_adr), 32'h0000_0400);
                    check("t2_vid_rdata", vid_rdata, 32'h1111_0000 + 32'(r));
                end
                if (cpu_ack) begin order.push_back(1); drop_c = 1'b1; end
                cyc();
                if (drop_v) vid_req = 1'b0;
                if (drop_c) cpu_req = 1'b0;
            end
            check("t2_count", 32'(order.size()), 32'd2);
            check("t2_first_vid", 32'(order[0]), 32'd2);
            check("t2_second_cpu", 32'(order[1]), 32'd1);
        end

        // CPU byte store: strobes stable until ack even if CPU inputs change
        resp_lat = 4; resp_data = 32'h0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_ben = 1'b1; cpu_adr = 24'h000103; cpu_wdata = 32'h5B00_0000;
        n_mreq = 0; ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_req) begin
                n_mreq++;
                check("t3_adr",   32'(mem_adr), 32'h0000_0103);
                check("t3_ben",   32'(mem_ben), 32'd1);
                check("t3_we",    32'(mem_we),  32'd1);
                check("t3_wdata", mem_wdata,    32'h5B00_0000);
            end
            if (cpu_ack) begin ok = 1; break; end
            cyc();
            if (n_mreq > 0) begin cpu_adr = 24'hFFFFFF; cpu_wdata = 32'h0; end
        end
        check("t3_ack_seen", 32'(ok), 32'd1);
        check("t3_mreq_cycles", 32'(n_mreq), 32'd5);
        cyc(); cpu_req = 1'b0; cpu_we = 1'b0; cpu_ben = 1'b0;

        // Timeout: no mem_ack at all
        resp_lat = 0;
        cpu_req = 1'b1; cpu_adr = 24'h000020;
        n_mreq = 0; ok = 0; got = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) n_mreq++;
            if (cpu_ack) begin got = cpu_rdata; ok = 1; break; end
            cyc();
        end
        check("t4_ack_seen", 32'(ok), 32'd1);
        check("t4_ack_cycle", 32'(n_mreq), 32'd16);
        check("t4_err_word", got, 32'hFFFF_FFFF);
        cyc(); cpu_req = 1'b0;
        @(negedge clk);
        check("t4_err_set", 32'(err), 32'd1);
        cyc(); cyc();
        @(negedge clk);
        check("t4_err_sticky", 32'(err), 32'd1);
        cyc();

        // Video request dropped after grant still completes
        resp_lat = 2; resp_data = 32'hA5A5_0001;
        vid_req = 1'b1; vid_adr = 24'h000804;
        cyc(); vid_req = 1'b0;
        ok = 0; got = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vid_ack) begin got = vid_rdata; ok = 1; break; end
            cyc();
        end
        check("t5_vid_ack_seen", 32'(ok), 32'd1);
        check("t5_vid_rdata", got, 32'hA5A5_0001);

        // Spurious mem_ack while idle is ignored
        cyc(); resp_lat = 0; resp_data = 32'h0BAD_0BAD; force_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5_idle_cpu_ack", 32'(cpu_ack), 32'd0);
            check("t5_idle_vid_ack", 32'(vid_ack), 32'd0);
            check("t5_idle_mem_req", 32'(mem_req), 32'd0);
            check("t5_vid_hold", vid_rdata, 32'hA5A5_0001);
            cyc();
        end
        force_ack = 1'b0;

        // Reset in the 2nd cycle of a video access abandons it
        @(negedge clk);
        check("t6_err_before_rst", 32'(err), 32'd1);
        cyc();
        vid_req = 1'b1; vid_adr = 24'h000C00;
        cyc(); vid_req = 1'b0;
        cyc(); rst = 1'b0; force_ack = 1'b1;
        @(negedge clk);
        check("t6_no_vid_ack", 32'(vid_ack), 32'd0);
        cyc(); rst = 1'b1; force_ack = 1'b0;
        @(negedge clk);
        check("t6_mem_req_off", 32'(mem_req), 32'd0);
        check("t6_err_cleared", 32'(err), 32'd0);
        check("t6_vid_rdata_cleared", vid_rdata, 32'd0);
        cyc();
        @(negedge clk);
        check("t6_still_idle", 32'(mem_req), 32'd0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
